// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared defaults, field tags and the buffered result-entry record for alu_wb.
package alu_wb_pkg;
    localparam int DEPTH_DEF  = 4;
    localparam int RW_DEF     = 4;
    localparam int RW_MAX     = 8;
    localparam int TAG_DATA_W = 16;
    localparam int TAG_CARRY  = 16;
    typedef struct packed {
        logic [RW_MAX-1:0]     rd;
        logic [TAG_DATA_W-1:0] data;
        logic                  wr_f;
        logic                  carry;
    } res_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: result buffer storage, pointers and occupancy count.
// Ports: clk, rst (async active-low), i_push/i_pop requests, i_din entry;
// o_mem exposes all slots, o_rd_ptr the head slot, o_count occupancy (0..DEPTH),
// o_ovf_evt pulses when a push is refused because the buffer is full with no pop.
module wb_fifo import alu_wb_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  res_entry_t                     i_din,
    output res_entry_t [DEPTH-1:0]         o_mem,
    output logic [$clog2(DEPTH)-1:0]       o_rd_ptr,
    output logic [$clog2(DEPTH):0]         o_count,
    output logic                           o_ovf_evt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    res_entry_t [DEPTH-1:0] r_mem;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   w_full;
    logic                   w_acc;
    assign w_full    = r_count == FULL;
    // a full buffer still accepts a push when the head leaves on the same edge
    assign w_acc     = i_push && (!w_full || i_pop);
    assign o_ovf_evt = i_push && w_full && !i_pop;
    assign o_mem     = r_mem;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_count   = r_count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_acc) - CW'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/alu_wb.sv
// alu_wb: buffers arith results and drains them to the register file, with operand forwarding.
// Ports: clk, rst (async active-low); res_valid/res_wr_f/res_data/res_rd arith result in;
// ex_rs1/ex_rs2 execute-stage sources; rf_gnt RF port grant;
// rf_we/rf_waddr/rf_wdata RF write; flag_we/flag_wdata carry write;
// fwd_en1/2 + fwd_data1/2 forwarding; stall issue hold; ovf sticky overflow.
module alu_wb import alu_wb_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          res_valid,
    input  logic          res_wr_f,
    input  logic [31:0]   res_data,
    input  logic [RW-1:0] res_rd,
    input  logic [RW-1:0] ex_rs1,
    input  logic [RW-1:0] ex_rs2,
    input  logic          rf_gnt,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [15:0]   rf_wdata,
    output logic          flag_we,
    output logic          flag_wdata,
    output logic          fwd_en1,
    output logic          fwd_en2,
    output logic [15:0]   fwd_data1,
    output logic [15:0]   fwd_data2,
    output logic          stall,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    res_entry_t [DEPTH-1:0] w_mem;
    res_entry_t             w_ent;
    res_entry_t             w_hd;
    logic [AW-1:0]          w_rd_ptr;
    logic [CW-1:0]          w_count;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ovf_evt;
    logic [16:0]            w_f1;
    logic [16:0]            w_f2;
    logic                   r_ovf;
    logic                   w_unused_hi;
    // walk oldest to youngest so the last hit is the youngest writer of rs
    function automatic logic [16:0] fwd_find(
        input logic [RW-1:0]        rs,
        input res_entry_t [DEPTH-1:0] m,
        input logic [AW-1:0]        head,
        input logic [CW-1:0]        cnt
    );
        logic [16:0]   r;
        logic [AW-1:0] idx;
        r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (k < int'(cnt) && rs != '0 && m[idx].rd == RW_MAX'(rs)) r = {1'b1, m[idx].data};
        end
        return r;
    endfunction
    assign w_unused_hi = ^res_data[31:17];
    assign w_push = res_valid && res_rd != '0;
    assign w_ent  = '{rd: RW_MAX'(res_rd), data: res_data[15:0], wr_f: res_wr_f, carry: res_data[TAG_CARRY]};
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_din     (w_ent),
        .o_mem     (w_mem),
        .o_rd_ptr  (w_rd_ptr),
        .o_count   (w_count),
        .o_ovf_evt (w_ovf_evt)
    );
    // payload storage is not reset, so head fields are gated by non-empty
    assign w_hd       = w_mem[w_rd_ptr];
    assign rf_we      = w_count != '0;
    assign w_pop      = rf_we && rf_gnt;
    assign rf_waddr   = rf_we ? RW'(w_hd.rd) : '0;
    assign rf_wdata   = rf_we ? w_hd.data : '0;
    assign flag_we    = w_pop && w_hd.wr_f;
    assign flag_wdata = rf_we && w_hd.carry;
    assign stall      = w_count >= CW'(DEPTH - 1);
    assign w_f1       = fwd_find(ex_rs1, w_mem, w_rd_ptr, w_count);
    assign w_f2       = fwd_find(ex_rs2, w_mem, w_rd_ptr, w_count);
    assign fwd_en1    = w_f1[16];
    assign fwd_data1  = w_f1[15:0];
    assign fwd_en2    = w_f2[16];
    assign fwd_data2  = w_f2[15:0];
    assign ovf        = r_ovf;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ovf <= 1'b0;
        else if (w_ovf_evt) r_ovf <= 1'b1;
    end
endmodule

// File: tb/tb_alu_wb.sv
// tb_alu_wb: directed self-checking bench for alu_wb.
module tb_alu_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid, res_wr_f, rf_gnt;
    logic [31:0] res_data;
    logic [3:0]  res_rd, ex_rs1, ex_rs2;
    logic        rf_we, flag_we, flag_wdata, fwd_en1, fwd_en2, stall, ovf;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata, fwd_data1, fwd_data2;
    int n_checks = 0;
    int n_errors = 0;

    alu_wb #(.DEPTH(4), .RW(4)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_wr_f(res_wr_f),
        .res_data(res_data), .res_rd(res_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .rf_gnt(rf_gnt), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_we(flag_we), .flag_wdata(flag_wdata), .fwd_en1(fwd_en1), .fwd_en2(fwd_en2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .stall(stall), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] rd, input logic [31:0] d, input logic f);
        res_valid = 1'b1; res_rd = rd; res_data = d; res_wr_f = f;
    endtask

    task automatic head(input string tag, input logic [3:0] a, input logic [15:0] d);
        chk({tag, "_we"}, rf_we, 1);
        chk({tag, "_addr"}, rf_waddr, a);
        chk({tag, "_data"}, rf_wdata, d);
    endtask

    initial begin
        rst = 1'b0; res_valid = 0; res_wr_f = 0; res_data = 0; res_rd = 0;
        ex_rs1 = 0; ex_rs2 = 0; rf_gnt = 0;
        step(); step();
        chk("rst_we", rf_we, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fwd1", fwd_en1, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_flag", flag_we, 0);
        chk("rst_ovf", ovf, 0);
        // single push, granted as soon as presented
        rst = 1'b1;
        push(3, 32'h0000_1234, 0); rf_gnt = 1;
        step();
        res_valid = 0;
        head("single", 3, 16'h1234);
        chk("single_flag", flag_we, 0);
        step();
        chk("single_empty", rf_we, 0);
        // carry result held until granted
        push(2, 32'h0001_0005, 1); rf_gnt = 0;
        step();
        res_valid = 0;
        head("carry", 2, 16'h0005);
        chk("carry_flag_nognt", flag_we, 0);
        chk("carry_fdata", flag_wdata, 1);
        rf_gnt = 1; #1;
        chk("carry_flag_we", flag_we, 1);
        step();
        chk("carry_empty", rf_we, 0);
        // writes to r0 are discarded
        push(0, 32'h0000_FFFF, 1);
        step();
        res_valid = 0;
        chk("r0_drop", rf_we, 0);
        // forwarding priority and fill
        rf_gnt = 0;
        push(5, 32'h0000_0011, 0); step();
        push(5, 32'h0000_0022, 0); step();
        res_valid = 0; ex_rs1 = 5; ex_rs2 = 0; #1;
        chk("fwd1_en", fwd_en1, 1);
        chk("fwd1_data", fwd_data1, 16'h0022);
        chk("fwd2_zero_en", fwd_en2, 0);
        chk("fwd2_zero_data", fwd_data2, 0);
        head("fwd_head", 5, 16'h0011);
        chk("stall_cnt2", stall, 0);
        push(7, 32'h0000_0077, 0); step();
        res_valid = 0; ex_rs2 = 7; #1;
        chk("stall_cnt3", stall, 1);
        chk("fwd2_en", fwd_en2, 1);
        chk("fwd2_data", fwd_data2, 16'h0077);
        ex_rs2 = 9; #1;
        chk("fwd2_miss", fwd_en2, 0);
        push(9, 32'h0000_0099, 0); step();
        res_valid = 0; #1;
        chk("full_ovf0", ovf, 0);
        chk("full_stall", stall, 1);
        chk("fwd2_r9", fwd_data2, 16'h0099);
        // full with simultaneous push and pop
        push(11, 32'h0000_00BB, 0); rf_gnt = 1;
        step();
        res_valid = 0; rf_gnt = 0; #1;
        chk("pp_ovf0", ovf, 0);
        chk("pp_stall", stall, 1);
        head("pp_head", 5, 16'h0022);
        // push into full buffer without pop is dropped
        push(12, 32'h0000_00CC, 0);
        step();
        res_valid = 0; #1;
        chk("drop_ovf", ovf, 1);
        // drain: popped entry still forwards during its pop cycle
        rf_gnt = 1; ex_rs1 = 5; #1;
        chk("pop_fwd_en", fwd_en1, 1);
        chk("pop_fwd_data", fwd_data1, 16'h0022);
        step();
        head("drain1", 7, 16'h0077);
        chk("drain1_fwd1", fwd_en1, 0);
        step();
        head("drain2", 9, 16'h0099);
        step();
        head("drain3", 11, 16'h00BB);
        chk("drain3_stall", stall, 0);
        step();
        chk("drain_empty", rf_we, 0);
        chk("ovf_sticky", ovf, 1);
        // reset mid-operation discards buffered entries
        rf_gnt = 0;
        push(6, 32'h0000_0066, 0); step();
        push(8, 32'h0000_0088, 0); step();
        res_valid = 0; ex_rs1 = 6;
        head("pre_rst", 6, 16'h0066);
        rst = 1'b0; #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_fwd", fwd_en1, 0);
        chk("mid_rst_ovf", ovf, 0);
        rf_gnt = 1;
        step();
        chk("mid_rst_hold", rf_we, 0);
        // first push accepted on first edge after release
        rst = 1'b1;
        push(4, 32'h0000_0044, 0);
        step();
        res_valid = 0;
        head("post_rst", 4, 16'h0044);
        step();
        chk("post_rst_empty", rf_we, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
